// File: rtl/controle_contagem_if.sv
`default_nettype none
// ============================================================================
// Module   : controle_contagem_if
// Brief    : Control/status bundle between a down-counter supervisor and its user.
// Revision : 1.0
// ============================================================================
interface controle_contagem_if;
    logic       start;
    logic       stop;
    logic [3:0] count_in;
    logic       load;
    logic [3:0] preset;
    logic [1:0] phase;
    logic       busy;
    logic       done;
    logic       err;

    modport master (
        output start, stop, count_in,
        input  load, preset, phase, busy, done, err
    );

    modport slave (
        input  start, stop, count_in,
        output load, preset, phase, busy, done, err
    );
endinterface
`default_nettype wire

// File: rtl/controle_contagem.sv
`default_nettype none
// ============================================================================
// Module   : controle_contagem
// Brief    : Sequences an external down-counter through three preset phases,
//            flagging illegal steps and stalls.
// Revision : 1.0
// ============================================================================
module controle_contagem #(
    parameter logic [3:0] P0      = 4'd3,
    parameter logic [3:0] P1      = 4'd2,
    parameter logic [3:0] P2      = 4'd1,
    parameter int         TIMEOUT = 15
) (
    input  wire logic          clk,
    input  wire logic          reset,
    controle_contagem_if.slave bus
);

    localparam int SW = (TIMEOUT < 2) ? 1 : $clog2(TIMEOUT + 1);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_LOAD = 2'd1,
        S_RUN  = 2'd2
    } state_t;

    state_t          state_q,  state_d;
    logic            load_q,   load_d;
    logic [3:0]      preset_q, preset_d;
    logic [1:0]      phase_q,  phase_d;
    logic            busy_q,   busy_d;
    logic            done_q,   done_d;
    logic            err_q,    err_d;
    logic [3:0]      prev_q,   prev_d;
    logic [SW-1:0]   stall_q,  stall_d;

    logic            same;
    logic            step_down;
    logic            legal;
    logic [SW-1:0]   stall_inc;

    // A decrement from 0 would be the 0->15 wrap, which is not a legal step.
    assign same      = (bus.count_in == prev_q);
    assign step_down = (prev_q != 4'd0) && (bus.count_in == (prev_q - 4'd1));
    assign legal     = same || step_down;
    assign stall_inc = stall_q + SW'(1);

    always_comb begin
        state_d  = state_q;
        load_d   = 1'b0;
        done_d   = 1'b0;
        busy_d   = busy_q;
        preset_d = preset_q;
        phase_d  = phase_q;
        err_d    = err_q;
        prev_d   = prev_q;
        stall_d  = stall_q;

        case (state_q)
            S_IDLE: begin
                busy_d = 1'b0;
                if (bus.start) begin
                    state_d  = S_LOAD;
                    phase_d  = 2'd0;
                    preset_d = P0;
                    err_d    = 1'b0;
                    load_d   = 1'b1;
                    busy_d   = 1'b1;
                    stall_d  = '0;
                end
            end

            S_LOAD: begin
                prev_d  = preset_q;
                stall_d = '0;
                if (bus.stop) begin
                    state_d = S_IDLE;
                    busy_d  = 1'b0;
                end else begin
                    state_d = S_RUN;
                end
            end

            S_RUN: begin
                prev_d  = bus.count_in;
                stall_d = same ? stall_inc : '0;
                if (bus.stop) begin
                    state_d = S_IDLE;
                    busy_d  = 1'b0;
                end else if (!legal) begin
                    state_d = S_IDLE;
                    busy_d  = 1'b0;
                    err_d   = 1'b1;
                end else if (same && (stall_inc == SW'(TIMEOUT))) begin
                    state_d = S_IDLE;
                    busy_d  = 1'b0;
                    err_d   = 1'b1;
                end else if (bus.count_in == 4'd0) begin
                    if (phase_q == 2'd2) begin
                        state_d = S_IDLE;
                        busy_d  = 1'b0;
                        done_d  = 1'b1;
                    end else begin
                        state_d  = S_LOAD;
                        load_d   = 1'b1;
                        phase_d  = phase_q + 2'd1;
                        preset_d = (phase_q == 2'd0) ? P1 : P2;
                    end
                end
            end

            default: begin
                state_d = S_IDLE;
                busy_d  = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q  <= S_IDLE;
            load_q   <= 1'b0;
            preset_q <= P0;
            phase_q  <= 2'd0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
            err_q    <= 1'b0;
            prev_q   <= 4'd0;
            stall_q  <= '0;
        end else begin
            state_q  <= state_d;
            load_q   <= load_d;
            preset_q <= preset_d;
            phase_q  <= phase_d;
            busy_q   <= busy_d;
            done_q   <= done_d;
            err_q    <= err_d;
            prev_q   <= prev_d;
            stall_q  <= stall_d;
        end
    end

    assign bus.load   = load_q;
    assign bus.preset = preset_q;
    assign bus.phase  = phase_q;
    assign bus.busy   = busy_q;
    assign bus.done   = done_q;
    assign bus.err    = err_q;

endmodule
`default_nettype wire

// File: tb/tb_controle_contagem.sv
`default_nettype none
// ============================================================================
// Module   : tb_controle_contagem
// Brief    : Scenario bench for controle_contagem with a load-event scoreboard.
// Revision : 1.0
// ============================================================================
module tb_controle_contagem;

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    controle_contagem_if bus();

    controle_contagem #(
        .P0(4'd3), .P1(4'd2), .P2(4'd1), .TIMEOUT(15)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    // {load, preset, phase, busy, done, err}
    localparam logic [9:0] RST_VEC = {1'b0, 4'd3, 2'd0, 1'b0, 1'b0, 1'b0};

    int checks    = 0;
    int failures  = 0;
    int done_seen = 0;
    logic [5:0] exp_q[$];
    logic [5:0] obs_q[$];

    // Capture every load pulse as {phase, preset}, and count done pulses.
    always @(negedge clk) begin
        if (bus.load === 1'b1) obs_q.push_back({bus.phase, bus.preset});
        if (bus.done === 1'b1) done_seen++;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog expired");
    end

    task automatic cyc(input int n);
        repeat (n) begin
            @(negedge clk);
            #1;
        end
    endtask

    task automatic pulse_start();
        bus.start = 1'b1;
        cyc(1);
        bus.start = 1'b0;
    endtask

    // One LOAD cycle, then a clean countdown from p to 0 in RUN.
    task automatic feed_phase(input logic [3:0] p);
        bus.count_in = p;
        cyc(1);
        for (int v = int'(p); v >= 0; v--) begin
            bus.count_in = 4'(v);
            cyc(1);
        end
    endtask

    task automatic test_reset();
        logic [9:0] got;
        got = {bus.load, bus.preset, bus.phase, bus.busy, bus.done, bus.err};
        checks++;
        if (got !== RST_VEC) begin
            failures++;
            $display("FAIL reset_state: got %b expected %b", got, RST_VEC);
        end
        reset = 1'b1;
        cyc(2);
        got = {bus.load, bus.preset, bus.phase, bus.busy, bus.done, bus.err};
        checks++;
        if (got !== RST_VEC) begin
            failures++;
            $display("FAIL post_release_idle: got %b expected %b", got, RST_VEC);
        end
    endtask

    task automatic test_nominal();
        int d0;
        logic [5:0] e, o;
        exp_q.delete(); obs_q.delete();
        d0 = done_seen;
        pulse_start();
        exp_q.push_back({2'd0, 4'd3});
        checks++;
        if ({bus.load, bus.busy} !== 2'b11) begin
            failures++;
            $display("FAIL nominal_load_busy: got %b expected 11", {bus.load, bus.busy});
        end
        feed_phase(4'd3);
        exp_q.push_back({2'd1, 4'd2});
        checks++;
        if ({bus.load, bus.phase, bus.preset} !== {1'b1, 2'd1, 4'd2}) begin
            failures++;
            $display("FAIL zero_to_load_latency: got %b expected %b",
                     {bus.load, bus.phase, bus.preset}, {1'b1, 2'd1, 4'd2});
        end
        feed_phase(4'd2);
        exp_q.push_back({2'd2, 4'd1});
        feed_phase(4'd1);
        checks++;
        if ({bus.done, bus.busy, bus.err} !== 3'b100) begin
            failures++;
            $display("FAIL nominal_done: got %b expected 100", {bus.done, bus.busy, bus.err});
        end
        cyc(1);
        checks++;
        if (bus.done !== 1'b0) begin
            failures++;
            $display("FAIL done_one_cycle: got %b expected 0", bus.done);
        end
        checks++;
        if (done_seen - d0 != 1) begin
            failures++;
            $display("FAIL nominal_done_count: got %0d expected 1", done_seen - d0);
        end
        while (exp_q.size() > 0 && obs_q.size() > 0) begin
            e = exp_q.pop_front();
            o = obs_q.pop_front();
            checks++;
            if (o !== e) begin
                failures++;
                $display("FAIL nominal_load_event: got %h expected %h", o, e);
            end
        end
        checks++;
        if (exp_q.size() != 0 || obs_q.size() != 0) begin
            failures++;
            $display("FAIL nominal_load_count: leftover expected %0d observed %0d",
                     exp_q.size(), obs_q.size());
        end
    endtask

    task automatic test_hold();
        int d0;
        logic [5:0] e, o;
        exp_q.delete(); obs_q.delete();
        d0 = done_seen;
        pulse_start();
        exp_q.push_back({2'd0, 4'd3});
        bus.count_in = 4'd3; cyc(2);
        bus.count_in = 4'd2; cyc(5);
        checks++;
        if ({bus.err, bus.busy} !== 2'b01) begin
            failures++;
            $display("FAIL hold_no_err: got %b expected 01", {bus.err, bus.busy});
        end
        bus.count_in = 4'd1; cyc(1);
        bus.count_in = 4'd0; cyc(1);
        exp_q.push_back({2'd1, 4'd2});
        feed_phase(4'd2);
        exp_q.push_back({2'd2, 4'd1});
        feed_phase(4'd1);
        cyc(1);
        checks++;
        if (done_seen - d0 != 1 || bus.err !== 1'b0) begin
            failures++;
            $display("FAIL hold_complete: got done=%0d err=%b expected done=1 err=0",
                     done_seen - d0, bus.err);
        end
        while (exp_q.size() > 0 && obs_q.size() > 0) begin
            e = exp_q.pop_front();
            o = obs_q.pop_front();
            checks++;
            if (o !== e) begin
                failures++;
                $display("FAIL hold_load_event: got %h expected %h", o, e);
            end
        end
        checks++;
        if (exp_q.size() != 0 || obs_q.size() != 0) begin
            failures++;
            $display("FAIL hold_load_count: leftover expected %0d observed %0d",
                     exp_q.size(), obs_q.size());
        end
    endtask

    task automatic test_illegal();
        int d0;
        d0 = done_seen;
        pulse_start();
        bus.count_in = 4'd3; cyc(2);
        bus.count_in = 4'd1; cyc(1);
        checks++;
        if ({bus.err, bus.busy, bus.done} !== 3'b100) begin
            failures++;
            $display("FAIL illegal_jump: got %b expected 100", {bus.err, bus.busy, bus.done});
        end
        cyc(2);
        checks++;
        if (done_seen != d0) begin
            failures++;
            $display("FAIL illegal_no_done: got %0d expected 0", done_seen - d0);
        end
        pulse_start();
        checks++;
        if ({bus.err, bus.load} !== 2'b01) begin
            failures++;
            $display("FAIL start_clears_err: got %b expected 01", {bus.err, bus.load});
        end
        bus.count_in = 4'd3; cyc(2);
        bus.count_in = 4'd4; cyc(1);
        checks++;
        if ({bus.err, bus.busy} !== 2'b10) begin
            failures++;
            $display("FAIL illegal_increase: got %b expected 10", {bus.err, bus.busy});
        end
    endtask

    task automatic test_stall();
        pulse_start();
        bus.count_in = 4'd3; cyc(2);
        bus.count_in = 4'd2; cyc(1);
        cyc(14);
        checks++;
        if ({bus.err, bus.busy} !== 2'b01) begin
            failures++;
            $display("FAIL stall_below_timeout: got %b expected 01", {bus.err, bus.busy});
        end
        cyc(1);
        checks++;
        if ({bus.err, bus.busy} !== 2'b10) begin
            failures++;
            $display("FAIL stall_timeout: got %b expected 10", {bus.err, bus.busy});
        end
    endtask

    task automatic test_simultaneous();
        int d0;
        logic [5:0] e, o;
        exp_q.delete(); obs_q.delete();
        d0 = done_seen;
        bus.start = 1'b1; bus.stop = 1'b1; cyc(1);
        bus.start = 1'b0; bus.stop = 1'b0;
        exp_q.push_back({2'd0, 4'd3});
        checks++;
        if ({bus.load, bus.busy, bus.err} !== 3'b110) begin
            failures++;
            $display("FAIL start_beats_stop: got %b expected 110", {bus.load, bus.busy, bus.err});
        end
        feed_phase(4'd3);
        exp_q.push_back({2'd1, 4'd2});
        feed_phase(4'd2);
        exp_q.push_back({2'd2, 4'd1});
        bus.count_in = 4'd1; cyc(2);
        bus.count_in = 4'd0; bus.stop = 1'b1; cyc(1);
        bus.stop = 1'b0;
        checks++;
        if ({bus.busy, bus.done, bus.err} !== 3'b000) begin
            failures++;
            $display("FAIL stop_beats_zero: got %b expected 000", {bus.busy, bus.done, bus.err});
        end
        cyc(1);
        checks++;
        if (done_seen != d0) begin
            failures++;
            $display("FAIL stop_no_done: got %0d expected 0", done_seen - d0);
        end
        pulse_start();
        exp_q.push_back({2'd0, 4'd3});
        bus.count_in = 4'd3; cyc(1);
        bus.start = 1'b1; cyc(1);
        bus.start = 1'b0;
        checks++;
        if ({bus.load, bus.busy, bus.phase, bus.preset} !== {1'b0, 1'b1, 2'd0, 4'd3}) begin
            failures++;
            $display("FAIL start_while_busy: got %b expected %b",
                     {bus.load, bus.busy, bus.phase, bus.preset}, {1'b0, 1'b1, 2'd0, 4'd3});
        end
        bus.count_in = 4'd2; bus.stop = 1'b1; cyc(1);
        bus.stop = 1'b0;
        checks++;
        if (bus.busy !== 1'b0) begin
            failures++;
            $display("FAIL stop_in_run: got busy=%b expected 0", bus.busy);
        end
        pulse_start();
        exp_q.push_back({2'd0, 4'd3});
        bus.stop = 1'b1; cyc(1);
        bus.stop = 1'b0;
        checks++;
        if ({bus.busy, bus.load} !== 2'b00) begin
            failures++;
            $display("FAIL stop_in_load: got %b expected 00", {bus.busy, bus.load});
        end
        cyc(1);
        while (exp_q.size() > 0 && obs_q.size() > 0) begin
            e = exp_q.pop_front();
            o = obs_q.pop_front();
            checks++;
            if (o !== e) begin
                failures++;
                $display("FAIL simul_load_event: got %h expected %h", o, e);
            end
        end
        checks++;
        if (exp_q.size() != 0 || obs_q.size() != 0) begin
            failures++;
            $display("FAIL simul_load_count: leftover expected %0d observed %0d",
                     exp_q.size(), obs_q.size());
        end
    endtask

    task automatic test_reset_mid();
        int d0;
        logic [9:0] got;
        pulse_start();
        feed_phase(4'd3);
        bus.count_in = 4'd2; cyc(2);
        reset = 1'b0;
        #1;
        got = {bus.load, bus.preset, bus.phase, bus.busy, bus.done, bus.err};
        checks++;
        if (got !== RST_VEC) begin
            failures++;
            $display("FAIL reset_async: got %b expected %b", got, RST_VEC);
        end
        cyc(2);
        reset = 1'b1;
        obs_q.delete();
        d0 = done_seen;
        for (int v = 1; v >= 0; v--) begin
            bus.count_in = 4'(v);
            cyc(3);
        end
        checks++;
        if (bus.busy !== 1'b0 || obs_q.size() != 0 || done_seen != d0) begin
            failures++;
            $display("FAIL reset_stays_idle: got busy=%b loads=%0d dones=%0d expected 0 0 0",
                     bus.busy, obs_q.size(), done_seen - d0);
        end
    endtask

    initial begin
        reset        = 1'b0;
        bus.start    = 1'b0;
        bus.stop     = 1'b0;
        bus.count_in = 4'd0;
        cyc(2);
        test_reset();
        test_nominal();
        test_hold();
        test_illegal();
        test_stall();
        test_simultaneous();
        test_reset_mid();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire
